// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared state encoding and defaults for the debug halt controller
package debug_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_HALT      = 3'd1,
    ST_STEP_PASS = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_RESUME    = 3'd4
  } dbg_state_t;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - push-button conditioning: 2-flop sync, debounce, rising-edge pulse
module btn_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_q;

  // Accepted level starts high so a button held through reset must first be
  // seen released before a press can register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/debug_halt_ctrl.sv
// rtl/debug_halt_ctrl.sv - breakpoint / single-step halt controller for a CPU fetch stage
module debug_halt_ctrl
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] bp_addr,
  input  logic        bp_enable,
  input  logic [15:0] pc,
  input  logic        instr_fetch,
  input  logic        step_btn,
  input  logic        run_btn,
  input  logic        halt_btn,
  output logic        cpu_halt,
  output logic        halted,
  output logic        bp_hit,
  output logic [7:0]  hit_count
);

  dbg_state_t state;
  dbg_state_t next_state;
  logic       step_p;
  logic       run_p;
  logic       halt_p;
  logic       halt_req;
  logic       match;

  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clock(clock), .reset_n(reset_n), .btn(step_btn), .pulse(step_p)
  );
  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clock(clock), .reset_n(reset_n), .btn(run_btn), .pulse(run_p)
  );
  btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_halt (
    .clock(clock), .reset_n(reset_n), .btn(halt_btn), .pulse(halt_p)
  );

  assign match = bp_enable & instr_fetch & (pc == bp_addr);

  always_comb begin
    next_state = state;
    cpu_halt   = 1'b0;
    case (state)
      ST_RUN: begin
        cpu_halt = match | halt_req;
        if (match | halt_req) next_state = ST_HALT;
      end
      ST_HALT: begin
        cpu_halt = 1'b1;
        if (run_p)       next_state = ST_RESUME;
        else if (step_p) next_state = ST_STEP_PASS;
      end
      ST_STEP_PASS: begin
        if (instr_fetch) next_state = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        cpu_halt = instr_fetch;
        if (instr_fetch) next_state = ST_HALT;
      end
      // The breakpoint instruction itself must be let through once here.
      ST_RESUME: begin
        if (instr_fetch) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      halt_req  <= 1'b0;
      halted    <= 1'b0;
      bp_hit    <= 1'b0;
      hit_count <= 8'h00;
    end else begin
      state  <= next_state;
      halted <= (next_state == ST_HALT);
      bp_hit <= (state == ST_RUN) && match;
      if (state == ST_RUN && next_state != ST_HALT) begin
        if (halt_p) halt_req <= 1'b1;
      end else begin
        halt_req <= 1'b0;
      end
      if (state == ST_RUN && match && hit_count != 8'hFF) begin
        hit_count <= hit_count + 8'd1;
      end
    end
  end

endmodule
